// File: rtl/separable_channel_packer_16ch.sv
// ---------------------------------------------------------------------------
// separable_channel_packer_16ch
//
// Converts channel-serial words into channel-parallel pixels for the
// 16-channel depthwise stage. Each valid input word is one channel of the
// current pixel, with channel 0 first. After 16 words the block emits one
// packed pixel and pulses Valid_Out for one cycle. It also counts pixels
// within a frame and flags the last pixel of every frame.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   Data_In      one channel word (opaque bits)
//   Valid_In     Data_In is valid this cycle
//   Sync_In      with Valid_In, marks Data_In as channel 0 of a new pixel
//   Data_Out     packed pixel; channel k at [DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k]
//   Valid_Out    one-cycle pulse when Data_Out takes a new pixel
//   Frame_Done   one-cycle pulse with Valid_Out on the last pixel of a frame
//   Pixel_Count  frame index of the most recently emitted pixel
//   Align_Err    sticky; set when Sync_In arrives mid-pixel
// ---------------------------------------------------------------------------
module separable_channel_packer_16ch #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDHT-1:0]      Data_In,
  input  logic                       Valid_In,
  input  logic                       Sync_In,
  output logic [DATA_WIDHT*16-1:0]   Data_Out,
  output logic                       Valid_Out,
  output logic                       Frame_Done,
  output logic [15:0]                Pixel_Count,
  output logic                       Align_Err
);

  localparam logic [15:0] LAST_PIX = 16'(IMG_WIDHT * IMG_HEIGHT - 1);

  logic [3:0]            cnt;
  logic [DATA_WIDHT-1:0] lane [15];
  logic [15:0]           next_pix;

  // Channel 15 is never stored in a lane register. It goes straight into
  // Data_Out together with the 15 held lanes, so lane 0 can already be
  // overwritten by the next pixel in the same cycle that Valid_Out is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      next_pix    <= '0;
      Data_Out    <= '0;
      Valid_Out   <= 1'b0;
      Frame_Done  <= 1'b0;
      Pixel_Count <= '0;
      Align_Err   <= 1'b0;
      for (int k = 0; k < 15; k++) lane[k] <= '0;
    end else begin
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
      if (Valid_In) begin
        if (Sync_In && cnt != 4'd0) begin
          // A sync mid-pixel means the upstream lost alignment. Drop the
          // partial pixel and restart with this word as channel 0.
          lane[0]   <= Data_In;
          cnt       <= 4'd1;
          Align_Err <= 1'b1;
        end else if (cnt == 4'd15) begin
          for (int k = 0; k < 15; k++)
            Data_Out[k*DATA_WIDHT +: DATA_WIDHT] <= lane[k];
          Data_Out[15*DATA_WIDHT +: DATA_WIDHT] <= Data_In;
          Valid_Out   <= 1'b1;
          Pixel_Count <= next_pix;
          Frame_Done  <= (next_pix == LAST_PIX);
          next_pix    <= (next_pix == LAST_PIX) ? 16'd0 : next_pix + 16'd1;
          cnt         <= 4'd0;
        end else begin
          for (int k = 0; k < 15; k++)
            if (cnt == 4'(k)) lane[k] <= Data_In;
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_separable_channel_packer_16ch.sv
// ---------------------------------------------------------------------------
// tb_separable_channel_packer_16ch
//
// Self-checking bench for separable_channel_packer_16ch. As each word is
// driven, a small reference model assembles the pixels. Every completed
// pixel is pushed to a scoreboard queue along with the cycle in which its
// Valid_Out is due. A monitor pops and compares entries as the DUT emits
// pixels.
// ---------------------------------------------------------------------------
module tb_separable_channel_packer_16ch;

  localparam int DW  = 32;
  localparam int IW  = 44;
  localparam int IH  = 44;
  localparam int NPX = IW * IH;

  logic              clk;
  logic              rst;
  logic [DW-1:0]     Data_In;
  logic              Valid_In;
  logic              Sync_In;
  logic [DW*16-1:0]  Data_Out;
  logic              Valid_Out;
  logic              Frame_Done;
  logic [15:0]       Pixel_Count;
  logic              Align_Err;

  separable_channel_packer_16ch #(
    .DATA_WIDHT (DW),
    .IMG_WIDHT  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Data_In     (Data_In),
    .Valid_In    (Valid_In),
    .Sync_In     (Sync_In),
    .Data_Out    (Data_Out),
    .Valid_Out   (Valid_Out),
    .Frame_Done  (Frame_Done),
    .Pixel_Count (Pixel_Count),
    .Align_Err   (Align_Err)
  );

  typedef struct {
    logic [DW*16-1:0] data;
    logic [15:0]      pc;
    logic             fd;
    int               due;
  } exp_t;

  exp_t          sb[$];
  int            testsRun  = 0;
  int            testsFail = 0;
  int            cyc       = 0;
  int            fdCount   = 0;
  int            mCnt      = 0;
  int            mPix      = 0;
  logic [DW-1:0] mLane [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Absolute bound so the run always ends, even if the DUT wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [DW*16-1:0] act,
                             input logic [DW*16-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: assemble words into pixels and queue each expected pixel.
  task automatic modelStep(input logic v, input logic s, input logic [DW-1:0] d);
    exp_t e;
    if (!v) return;
    if (s && mCnt != 0) begin
      mLane[0] = d;
      mCnt     = 1;
    end else begin
      mLane[mCnt] = d;
      if (mCnt == 15) begin
        for (int i = 0; i < 16; i++) e.data[i*DW +: DW] = mLane[i];
        e.pc  = 16'(mPix);
        e.fd  = (mPix == NPX - 1);
        e.due = cyc + 1;
        sb.push_back(e);
        mPix = (mPix == NPX - 1) ? 0 : mPix + 1;
        mCnt = 0;
      end else begin
        mCnt++;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [DW-1:0] d);
    Valid_In = v;
    Sync_In  = s;
    Data_In  = d;
    modelStep(v, s, d);
    @(posedge clk);
    #1;
    Valid_In = 1'b0;
    Sync_In  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, $urandom);
  endtask

  task automatic sendPixel(input logic [DW-1:0] base);
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, k == 0, base + DW'(k));
  endtask

  // Monitor: each emitted pixel must match the head of the scoreboard and
  // appear exactly in its due cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (Valid_Out) begin
        if (Frame_Done) fdCount++;
        if (sb.size() == 0) begin
          checkOutput("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("valid_cycle", cyc, e.due);
          checkOutput("data_out", Data_Out, e.data);
          checkOutput("pixel_count", Pixel_Count, e.pc);
          checkOutput("frame_done", Frame_Done, e.fd);
        end
      end else begin
        if (Frame_Done) checkOutput("fd_without_valid", 1, 0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          checkOutput("missing_valid", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    Valid_In = 1'b0;
    Sync_In  = 1'b0;
    Data_In  = '0;
    for (int i = 0; i < 16; i++) mLane[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_data", Data_Out, 0);
    checkOutput("rst_valid", Valid_Out, 0);
    checkOutput("rst_fd", Frame_Done, 0);
    checkOutput("rst_pc", Pixel_Count, 0);
    checkOutput("rst_align", Align_Err, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic pixel with back-to-back words.
    sendPixel(32'h3F80_0000);
    idle(4);
    checkOutput("t1_ch0", Data_Out[31:0], 32'h3F80_0000);
    checkOutput("t1_ch15", Data_Out[511:480], 32'h3F80_000F);
    checkOutput("t1_pc", Pixel_Count, 0);
    checkOutput("t1_align", Align_Err, 0);

    // The same words with a gap after each one.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, k == 0, 32'h3F80_0000 + DW'(k));
      applyStimulus(1'b0, 1'b0, $urandom);
    end
    idle(3);
    checkOutput("t2_ch15", Data_Out[511:480], 32'h3F80_000F);
    checkOutput("t2_pc", Pixel_Count, 1);

    // Mid-pixel stall with Sync_In high but Valid_In low.
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, k == 0, 32'h1000_0000 + DW'(k));
    repeat (10) applyStimulus(1'b0, 1'b1, $urandom);
    for (int k = 7; k < 16; k++) applyStimulus(1'b1, 1'b0, 32'h1000_0000 + DW'(k));
    idle(3);
    checkOutput("hold_align", Align_Err, 0);
    checkOutput("hold_ch7", Data_Out[255:224], 32'h1000_0007);

    // Asynchronous reset in the middle of a pixel.
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, k == 0, 32'hDEAD_0000 + DW'(k));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_data", Data_Out, 0);
    checkOutput("arst_valid", Valid_Out, 0);
    checkOutput("arst_pc", Pixel_Count, 0);
    checkOutput("arst_fd", Frame_Done, 0);
    checkOutput("arst_align", Align_Err, 0);
    sb.delete();
    mCnt = 0;
    mPix = 0;
    for (int i = 0; i < 16; i++) mLane[i] = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sendPixel(32'h5555_0000);
    idle(3);
    checkOutput("post_rst_pc", Pixel_Count, 0);
    checkOutput("post_rst_ch0", Data_Out[31:0], 32'h5555_0000);

    // A full frame, streamed continuously, that crosses the wrap point.
    fdCount = 0;
    for (int p = 0; p < NPX; p++)
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, k == 0, $urandom);
    idle(4);
    checkOutput("frame_fd_count", fdCount, 1);
    checkOutput("frame_wrap_pc", Pixel_Count, 0);

    // A sync arrives after 5 words of a pixel.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, k == 0, 32'h7700_0000 + DW'(k));
    applyStimulus(1'b1, 1'b1, 32'hAAAA_AAAA);
    for (int k = 1; k < 16; k++) applyStimulus(1'b1, 1'b0, 32'hBB00_0000 + DW'(k));
    idle(3);
    checkOutput("mis_ch0", Data_Out[31:0], 32'hAAAA_AAAA);
    checkOutput("mis_align", Align_Err, 1);
    idle(10);
    checkOutput("mis_align_sticky", Align_Err, 1);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    checkOutput("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
